// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O conditioning block.
// Contents: default parameter values, the reset-sequencer state type and a
// constant ceil(log2()) helper used to size counters.
package board_io_pkg;

    localparam int DEFAULT_SW_WIDTH        = 16;
    localparam int DEFAULT_LED_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_RST_STRETCH     = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

    // Reset sequencer: HOLD while lock/reset-release are not both present,
    // STRETCH while counting, RUN once the SoC reset is released.
    typedef enum logic [1:0] {
        SEQ_HOLD    = 2'd0,
        SEQ_STRETCH = 2'd1,
        SEQ_RUN     = 2'd2
    } seq_state_e;

    // ceil(log2(value)), never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// Switch/LED bundle between the board pins, the SoC and board_io_ctrl.
//   sw_i        raw switch pins            sw_o        debounced levels
//   sw_change_o one-cycle change pulses    led_i       LED values from SoC
//   led_o       registered LED pins
// Modports: slave = board_io_ctrl, master = the pin/SoC side around it.
// There is no handshake: every signal is a level, sampled once per clock.
interface board_io_ctrl_if
    import board_io_pkg::*;
#(
    parameter int SW_WIDTH  = DEFAULT_SW_WIDTH,
    parameter int LED_WIDTH = DEFAULT_LED_WIDTH
);

    logic [SW_WIDTH-1:0]  sw_i;
    logic [SW_WIDTH-1:0]  sw_o;
    logic [SW_WIDTH-1:0]  sw_change_o;
    logic [LED_WIDTH-1:0] led_i;
    logic [LED_WIDTH-1:0] led_o;

    modport slave (
        input  sw_i,
        input  led_i,
        output sw_o,
        output sw_change_o,
        output led_o
    );

    modport master (
        output sw_i,
        output led_i,
        input  sw_o,
        input  sw_change_o,
        input  led_o
    );

endinterface

// File: rtl/sw_debounce.sv
// One-bit switch debouncer.
//   clk_i, arst_i  clock and asynchronous active-high reset
//   hold_i         high while the SoC is held in reset; suppresses the pulse
//   sw_i           raw (asynchronous) switch pin
//   sw_o           debounced level
//   sw_change_o    high for the cycle following a change of sw_o
// A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles in
// which the synchronised input differs from sw_o; any return to the current
// level restarts the count.
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic hold_i,
    input  logic sw_i,
    output logic sw_o,
    output logic sw_change_o
);

    localparam int            CW      = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   level_q, level_d;
    logic                   change_q, change_d;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            // Accept on the cycle the count would reach the limit; the counter
            // itself never holds CNT_MAX.
            if (cnt_inc == CNT_MAX) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        change_d = hold_i ? 1'b0 : (level_d != level_q);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            change_q <= change_d;
        end
    end

    assign sw_o        = level_q;
    assign sw_change_o = change_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board-level reset conditioning, switch debouncing and LED registering.
//   clk_i        system clock (PLL output)
//   arst_i       raw asynchronous active-high board reset
//   locked_i     PLL lock, asynchronous to clk_i
//   rst_o        stretched, synchronously released reset for the SoC
//   dbg_state_o  reset sequencer state
//   io           switch/LED bundle (slave side)
// rst_o is released RST_STRETCH cycles after both the synchronised reset
// release and the synchronised PLL lock are present; losing lock reasserts it.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int SW_WIDTH        = DEFAULT_SW_WIDTH,
    parameter int LED_WIDTH       = DEFAULT_LED_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int RST_STRETCH     = DEFAULT_RST_STRETCH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            locked_i,
    output logic            rst_o,
    output seq_state_e      dbg_state_o,
    board_io_ctrl_if.slave  io
);

    localparam int             RCW         = clog2(RST_STRETCH + 1);
    localparam logic [RCW-1:0] STRETCH_MAX = RCW'(RST_STRETCH);

    logic [SYNC_STAGES-1:0] rel_q;
    logic [SYNC_STAGES-1:0] lock_q;
    logic                   seq_ok;
    seq_state_e             state_q, state_d;
    logic [RCW-1:0]         cnt_q, cnt_d;
    logic                   rst_q, rst_d;
    logic [LED_WIDTH-1:0]   led_q, led_d;
    logic [SW_WIDTH-1:0]    sw_lvl, sw_chg;

    // Reset-release chain shifts in 1 so arst_i deassertion is seen
    // synchronously; lock chain brings locked_i into the clock domain.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rel_q  <= '0;
            lock_q <= '0;
        end else begin
            rel_q  <= {rel_q[SYNC_STAGES-2:0], 1'b1};
            lock_q <= {lock_q[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign seq_ok = rel_q[SYNC_STAGES-1] & lock_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!seq_ok) begin
            state_d = SEQ_HOLD;
            cnt_d   = '0;
        end else if (cnt_q != STRETCH_MAX) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == STRETCH_MAX) ? SEQ_RUN : SEQ_STRETCH;
        end else begin
            state_d = SEQ_RUN;
        end
        // rst_o comes straight from a flop so the SoC never sees decode glitches.
        rst_d = (state_d != SEQ_RUN);
        led_d = rst_q ? '0 : io.led_i;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= SEQ_HOLD;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            led_q   <= led_d;
        end
    end

    // Debouncers keep running during the reset stretch so sw_o is already
    // settled when the SoC comes out of reset; only the pulses are held off.
    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        sw_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i       (clk_i),
            .arst_i      (arst_i),
            .hold_i      (rst_q),
            .sw_i        (io.sw_i[i]),
            .sw_o        (sw_lvl[i]),
            .sw_change_o (sw_chg[i])
        );
    end

    assign rst_o          = rst_q;
    assign dbg_state_o    = state_q;
    assign io.sw_o        = sw_lvl;
    assign io.sw_change_o = sw_chg;
    assign io.led_o       = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Testbench for board_io_ctrl (SYNC_STAGES=2, RST_STRETCH=4, DEBOUNCE_CYCLES=8).
// Stimulus pushes hand-computed expectations tagged with the clock edge at
// which they must hold; a monitor 1 ns after every rising edge pops and
// compares them, and pops the pulse queue whenever sw_change_o is non-zero.
module tb_board_io_ctrl;
    import board_io_pkg::*;

    localparam int SW_W  = 16;
    localparam int LED_W = 16;
    localparam int SYNC  = 2;
    localparam int STR   = 4;
    localparam int DEB   = 8;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] val;
    } chk_t;

    // ---------------- clock / reset ----------------
    logic       clk    = 1'b0;
    logic       arst   = 1'b0;
    logic       locked = 1'b1;
    logic       rst_o;
    seq_state_e dbg_state;

    always #5 clk = ~clk;

    board_io_ctrl_if #(.SW_WIDTH(SW_W), .LED_WIDTH(LED_W)) io ();

    board_io_ctrl #(
        .SW_WIDTH        (SW_W),
        .LED_WIDTH       (LED_W),
        .SYNC_STAGES     (SYNC),
        .RST_STRETCH     (STR),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .locked_i    (locked),
        .rst_o       (rst_o),
        .dbg_state_o (dbg_state),
        .io          (io.slave)
    );

    // ---------------- scoreboard ----------------
    int              edge_n = 0;
    int              checks = 0;
    int              errors = 0;
    chk_t            tq[$];
    logic [SW_W-1:0] exp_q[$];
    string           sig_name[5] = '{"rst_o", "sw_o", "led_o", "sw_change_o", "dbg_state_o"};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sample(input int id);
        case (id)
            0:       return {15'b0, rst_o};
            1:       return io.sw_o;
            2:       return io.led_o;
            3:       return io.sw_change_o;
            default: return 16'(dbg_state);
        endcase
    endfunction

    task automatic expect_at(input int c, input int id, input logic [15:0] v);
        tq.push_back('{cyc: c, id: id, val: v});
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        edge_n++;
        for (int i = tq.size() - 1; i >= 0; i--) begin
            if (tq[i].cyc == edge_n) begin
                check($sformatf("%s@edge%0d", sig_name[tq[i].id], edge_n),
                      sample(tq[i].id), tq[i].val);
                tq.delete(i);
            end
        end
        if (io.sw_change_o != '0) begin
            if (exp_q.size() == 0) begin
                check($sformatf("sw_change_unexpected@edge%0d", edge_n), io.sw_change_o, 16'h0000);
            end else begin
                check($sformatf("sw_change_pulse@edge%0d", edge_n), io.sw_change_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic glitch(input int b, input int len);
        io.sw_i[b] = 1'b1;
        repeat (len) @(negedge clk);
        io.sw_i[b] = 1'b0;
    endtask

    initial begin
        int e;
        int r;
        int l;
        io.sw_i  = '0;
        io.led_i = 16'hA5A5;

        // Power-up: asynchronous reset values before any clock edge.
        #1 arst = 1'b1;
        #1;
        check("por_rst_o", {15'b0, rst_o}, 16'h0001);
        check("por_sw_o", io.sw_o, 16'h0000);
        check("por_sw_change_o", io.sw_change_o, 16'h0000);
        check("por_led_o", io.led_o, 16'h0000);

        // Release: rst_o low at edge SYNC+STR = 6, LEDs follow one edge later.
        repeat (3) @(negedge clk);
        e = edge_n;
        arst = 1'b0;
        expect_at(e + 2, 4, 16'(SEQ_HOLD));
        expect_at(e + 5, 0, 16'h0001);
        expect_at(e + 5, 4, 16'(SEQ_STRETCH));
        expect_at(e + 6, 0, 16'h0000);
        expect_at(e + 6, 4, 16'(SEQ_RUN));
        expect_at(e + 6, 2, 16'h0000);
        expect_at(e + 7, 2, 16'hA5A5);
        repeat (8) @(negedge clk);

        // LED latency of one cycle.
        e = edge_n;
        io.led_i = 16'h3C3C;
        expect_at(e + 1, 2, 16'h3C3C);
        repeat (2) @(negedge clk);

        // Clean step on bit 3: sw_o at edge 10, single pulse.
        e = edge_n;
        io.sw_i[3] = 1'b1;
        expect_at(e + 9, 1, 16'h0000);
        expect_at(e + 10, 1, 16'h0008);
        expect_at(e + 10, 3, 16'h0008);
        expect_at(e + 11, 3, 16'h0000);
        exp_q.push_back(16'h0008);
        repeat (14) @(negedge clk);

        // Bounce on bit 0: high 5, low 1, then high; accepted 10 edges after the last rise.
        e = edge_n;
        io.sw_i[0] = 1'b1;
        repeat (5) @(negedge clk);
        io.sw_i[0] = 1'b0;
        @(negedge clk);
        io.sw_i[0] = 1'b1;
        expect_at(e + 10, 1, 16'h0008);
        expect_at(e + 15, 1, 16'h0008);
        expect_at(e + 16, 1, 16'h0009);
        expect_at(e + 16, 3, 16'h0001);
        exp_q.push_back(16'h0001);
        repeat (14) @(negedge clk);

        // Glitches of 5 and DEB-1 cycles are rejected.
        e = edge_n;
        expect_at(e + 12, 1, 16'h0009);
        glitch(5, 5);
        repeat (12) @(negedge clk);
        e = edge_n;
        expect_at(e + 12, 1, 16'h0009);
        glitch(6, DEB - 1);
        repeat (12) @(negedge clk);

        // Two bits together give one combined pulse.
        e = edge_n;
        io.sw_i[2:1] = 2'b11;
        expect_at(e + 10, 1, 16'h000F);
        expect_at(e + 10, 3, 16'h0006);
        exp_q.push_back(16'h0006);
        repeat (13) @(negedge clk);

        // Lock drop for 3 cycles.
        e = edge_n;
        locked = 1'b0;
        expect_at(e + 2, 0, 16'h0000);
        expect_at(e + 3, 0, 16'h0001);
        expect_at(e + 4, 2, 16'h0000);
        expect_at(e + 8, 0, 16'h0001);
        expect_at(e + 9, 0, 16'h0000);
        expect_at(e + 10, 2, 16'h3C3C);
        repeat (3) @(negedge clk);
        locked = 1'b1;
        repeat (10) @(negedge clk);

        // Async reset mid-debounce of bit 4, with lock held low so the
        // debouncers settle during the reset stretch without any pulse.
        io.sw_i[4] = 1'b1;
        repeat (4) @(negedge clk);
        locked = 1'b0;
        #1 arst = 1'b1;
        #1;
        check("arst_rst_o", {15'b0, rst_o}, 16'h0001);
        check("arst_sw_o", io.sw_o, 16'h0000);
        check("arst_led_o", io.led_o, 16'h0000);
        check("arst_sw_change_o", io.sw_change_o, 16'h0000);
        #1 arst = 1'b0;
        r = edge_n;
        expect_at(r + 9, 1, 16'h0000);
        expect_at(r + 10, 1, 16'h001F);
        expect_at(r + 10, 0, 16'h0001);
        expect_at(r + 11, 3, 16'h0000);
        repeat (12) @(negedge clk);
        l = edge_n;
        locked = 1'b1;
        expect_at(l + 5, 0, 16'h0001);
        expect_at(l + 6, 0, 16'h0000);
        expect_at(l + 7, 2, 16'h3C3C);
        repeat (10) @(negedge clk);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && tq.size() != 0; i++) begin
            @(negedge clk);
        end
        check("pending_timed_checks", 16'(tq.size()), 16'h0000);
        check("pending_pulses", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
